// File: rtl/iicm_wr_engine.sv
// I2C single-master write engine: START, chip address (W), register address, 0..MAX_BYTES data bytes, STOP.
// Optional slave clock stretching in q2 of each bit slot is enabled by defining IICM_CLK_STRETCH_EN.
module iicm_wr_engine #(
    parameter int         QDIV      = 25,
    parameter int         MAX_BYTES = 4,
    parameter int         CNT_W     = $clog2(MAX_BYTES) + 1,
    parameter logic [7:0] CHIP_ADDR = 8'hD0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [7:0]             reg_addr,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    input  logic [CNT_W-1:0]       byte_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic                   sda_oe,
    output logic                   scl_oe,
    input  logic                   sda_i,
    input  logic                   scl_i
);
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_CHIP  = 3'd2;
    localparam logic [2:0] S_REG   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]             state_q, state_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic [1:0]             q_q, q_d;
    logic [3:0]             bit_q, bit_d;
    logic [7:0]             sh_q, sh_d;
    logic [7:0]             reg_q, reg_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [CNT_W-1:0]       rem_q, rem_d;
    logic                   nack_q, nack_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   nerr_q, nerr_d;

    logic byte_st, q_end, slot_end, ack_smp, nack_now, hold;

    assign byte_st  = (state_q == S_CHIP) || (state_q == S_REG) || (state_q == S_DATA);
    assign q_end    = (qcnt_q == QW'(QDIV - 1));
    assign slot_end = q_end && (q_q == 2'd3);
    assign ack_smp  = byte_st && (bit_q == 4'd8) && (q_q == 2'd3) && (qcnt_q == '0);
    assign nack_now = nack_q || (ack_smp && sda_i);

`ifdef IICM_CLK_STRETCH_EN
    // Slave holding SCL low freezes the quarter counter at the start of the high phase.
    assign hold = (q_q == 2'd2) && (qcnt_q == '0) && !scl_i;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        q_d     = q_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        reg_d   = reg_q;
        data_d  = data_q;
        rem_d   = rem_q;
        nack_d  = nack_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        nerr_d  = nerr_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_START;
                qcnt_d  = '0;
                q_d     = 2'd0;
                bit_d   = 4'd0;
                nack_d  = 1'b0;
                reg_d   = reg_addr;
                data_d  = wr_data;
                rem_d   = (byte_cnt > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : byte_cnt;
                nerr_d  = 1'b0;
                busy_d  = 1'b1;
            end
        end else begin
            if (!hold) begin
                if (q_end) begin
                    qcnt_d = '0;
                    q_d    = q_q + 2'd1;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            if (ack_smp && sda_i) begin
                nack_d = 1'b1;
                nerr_d = 1'b1;
            end
            if (slot_end) begin
                case (state_q)
                    S_START: begin
                        state_d = S_CHIP;
                        sh_d    = {CHIP_ADDR[7:1], 1'b0};
                        bit_d   = 4'd0;
                    end
                    S_CHIP, S_REG, S_DATA: begin
                        if (bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                        end else begin
                            bit_d  = 4'd0;
                            nack_d = 1'b0;
                            if (nack_now) begin
                                state_d = S_STOP;
                            end else if (state_q == S_CHIP) begin
                                state_d = S_REG;
                                sh_d    = reg_q;
                            end else if (rem_q == '0) begin
                                state_d = S_STOP;
                            end else begin
                                state_d = S_DATA;
                                sh_d    = data_q[7:0];
                                data_d  = data_q >> 8;
                                rem_d   = rem_q - CNT_W'(1);
                            end
                        end
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Pad drive decoded from registered state; SCL is low in q0-q1 of every bit slot.
    always_comb begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
        case (state_q)
            S_START: sda_oe = q_q[1];
            S_CHIP, S_REG, S_DATA: begin
                scl_oe = ~q_q[1];
                sda_oe = (bit_q == 4'd8) ? 1'b0 : ~sh_q[7];
            end
            S_STOP: begin
                sda_oe = (q_q != 2'd3);
                scl_oe = (q_q == 2'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            q_q     <= 2'd0;
            bit_q   <= 4'd0;
            sh_q    <= 8'd0;
            reg_q   <= 8'd0;
            data_q  <= '0;
            rem_q   <= '0;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            q_q     <= q_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nerr_q  <= nerr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign nack_err = nerr_q;
endmodule

// File: tb/tb_iicm_wr_engine.sv
// Bench for iicm_wr_engine: bus-level slave/monitor decodes START/STOP/bytes; a transaction-level model predicts bytes, NACK and busy length.
module tb_iicm_wr_engine;
    localparam int Q  = 2;
    localparam int MB = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    reg_addr = 8'h00;
    logic [8*MB-1:0] wr_data = '0;
    logic [CW-1:0] byte_cnt = '0;
    logic          busy, done, nack_err, sda_oe, scl_oe;
    logic          sda_i, scl_i;
    logic          slave_low = 1'b0;
    logic          stretch_hold = 1'b0;

    assign sda_i = ~sda_oe & ~slave_low;
    assign scl_i = ~scl_oe & ~stretch_hold;

    iicm_wr_engine #(.QDIV(Q), .MAX_BYTES(MB)) dut (
        .clk(clk), .rstn(rstn), .start(start), .reg_addr(reg_addr),
        .wr_data(wr_data), .byte_cnt(byte_cnt), .busy(busy), .done(done),
        .nack_err(nack_err), .sda_oe(sda_oe), .scl_oe(scl_oe),
        .sda_i(sda_i), .scl_i(scl_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Bus monitor and ACKing slave, working only from pad levels.
    logic [7:0] got[$];
    int   n_start = 0, n_stop = 0, busy_cyc = 0;
    int   bitcnt = 0, byte_no = 0, nack_at = -1;
    logic [7:0] shr = 8'h00;
    logic sda_p = 1'b1, scl_p = 1'b1;

    always @(posedge clk) begin
        if (busy) busy_cyc++;
        if (!rstn) begin
            bitcnt = 0;
            slave_low <= 1'b0;
        end else if (scl_p && scl_i && sda_p && !sda_i) begin
            n_start++;
            bitcnt = 0;
            byte_no = 0;
        end else if (scl_p && scl_i && !sda_p && sda_i) begin
            n_stop++;
        end else if (!scl_p && scl_i) begin
            if (bitcnt < 8) begin
                shr = {shr[6:0], sda_i};
                bitcnt++;
                if (bitcnt == 8) got.push_back(shr);
            end else begin
                bitcnt = 0;
                byte_no++;
            end
        end else if (scl_p && !scl_i) begin
            slave_low <= (bitcnt == 8) && (byte_no != nack_at);
        end
        sda_p = sda_i;
        scl_p = scl_i;
    end

    logic [7:0] exp_q[$];
    logic exp_nack;
    int   exp_busy, base_got, base_start, base_stop, base_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Must be called at a negedge; returns at the negedge one cycle after acceptance.
    task automatic launch(input logic [7:0] ra, input logic [8*MB-1:0] wd,
                          input logic [CW-1:0] bc, input int nk, input int extra);
        int n;
        n = (int'(bc) > MB) ? MB : int'(bc);
        exp_q.delete();
        exp_q.push_back(8'hD0);
        exp_q.push_back(ra);
        for (int k = 0; k < n; k++) exp_q.push_back(wd[8*k +: 8]);
        if (nk >= 0 && nk < exp_q.size()) begin
            exp_nack = 1'b1;
            while (exp_q.size() > nk + 1) void'(exp_q.pop_back());
        end else begin
            exp_nack = 1'b0;
        end
        exp_busy   = (2 + 9 * exp_q.size()) * 4 * Q + extra;
        nack_at    = nk;
        base_got   = got.size();
        base_start = n_start;
        base_stop  = n_stop;
        base_busy  = busy_cyc;
        reg_addr = ra;
        wr_data  = wd;
        byte_cnt = bc;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_width", done, 0);
        chk("nack_clr", nack_err, 0);
    endtask

    // Returns at the negedge where done is seen high.
    task automatic finish();
        for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1);
        chk("busy_fall", busy, 0);
        chk("busy_len", busy_cyc - base_busy, exp_busy);
        chk("nbytes", got.size() - base_got, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base_got + i < got.size()) chk("byte", got[base_got + i], exp_q[i]);
        chk("nack_err", nack_err, exp_nack);
        chk("n_start", n_start - base_start, 1);
        chk("n_stop", n_stop - base_stop, 1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [8*MB-1:0] wd;
        int nk;

        repeat (2) @(negedge clk);
        chk("rst_sda", sda_oe, 0);
        chk("rst_scl", scl_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack_err, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Abort in CHIP bit 3 (q1, SCL low) by reset.
        launch(8'h12, 32'h0, 3'd1, -1, 0);
        repeat (35) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_scl", scl_oe, 1);
        #1 rstn = 1'b0;
        #1;
        chk("arst_sda", sda_oe, 0);
        chk("arst_scl", scl_oe, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        launch(8'h00, 32'h0000_00A5, 3'd1, -1, 0);
        finish();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        launch(8'h5A, 32'hDEAD_BEEF, 3'd0, -1, 0);
        finish();
        @(negedge clk);

        // NACK on register byte, then back-to-back start the cycle after done.
        launch(8'hC3, 32'h1122_3344, 3'd3, 1, 0);
        finish();
        wd = 32'h8877_6655;
        launch(8'h9E, wd, 3'd7, -1, 0);
        repeat (100) @(negedge clk);
        reg_addr = 8'hFF;
        wr_data  = 32'h0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish();
        repeat (50) @(negedge clk);
        chk("ignored_busy", busy, 0);
        chk("ignored_start", n_start - base_start, 1);

        for (int t = 0; t < 6; t++) begin
            ra = 8'($urandom);
            wd = {$urandom};
            nk = int'($urandom_range(0, 9)) - 3;
            launch(ra, wd, 3'($urandom_range(0, 7)), nk, 0);
            finish();
            @(negedge clk);
        end

`ifdef IICM_CLK_STRETCH_EN
        launch(8'h3C, 32'h0000_0069, 3'd1, -1, 10);
        repeat (84) @(negedge clk);
        stretch_hold = 1'b1;
        repeat (10) @(negedge clk);
        stretch_hold = 1'b0;
        finish();
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iicm_wr_engine.md
Name: iicm_wr_engine

Overview:
- Parametrised I2C single-master write engine; next generation of the fixed chip/reg/data writer.
- Sends START, chip address (W), register address, 0..MAX_BYTES data bytes and STOP.
- Open-drain pad interface with per-byte ACK sampling, NACK abort, start/busy/done handshake and a programmable SCL rate.
- Sits between system control logic (supplies payload and start pulse) and the I2C pads.

Parameters:
- QDIV, 25: system clocks per SCL quarter-period; ≥1. SCL period = 4*QDIV clocks.
- MAX_BYTES, 4: maximum data bytes per transaction; ≥1.
- CNT_W, $clog2(MAX_BYTES)+1: width of byte_cnt.
- CHIP_ADDR, 8'hD0: 7-bit device address in bits [7:1]. Bit 0 is ignored; R/W is always sent as 0.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request pulse; accepted only when busy=0.
- reg_addr  input  8  register address byte.
- wr_data  input  8*MAX_BYTES  payload; byte k in bits [8k+7:8k]; byte 0 sent first.
- byte_cnt  input  CNT_W  data bytes to send; values above MAX_BYTES clamp to MAX_BYTES.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse at end of STOP.
- nack_err  output  1  sticky NACK flag; cleared on next accepted start.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- scl_oe  output  1  1 = pull SCL low; 0 = release.
- sda_i  input  1  SDA pad level.
- scl_i  input  1  SCL pad level (used only with the optional feature).

Behaviour:
- Reset (async, rstn=0): state IDLE; sda_oe=0, scl_oe=0, busy=0, done=0, nack_err=0; counters and shift register cleared. Reset mid-transaction releases both lines immediately, with no STOP.
- Accept: start=1 with busy=0 latches reg_addr, wr_data and clamped byte_cnt. Clears nack_err. busy=1 from the next cycle. start while busy=1 is ignored.
- Timing: quarter counter counts 0..QDIV-1, then advances quarter q 0..3; 4 quarters = 1 bit slot.
- States: IDLE -> START -> CHIP -> REG -> DATA (repeats byte_cnt times; skipped if 0) -> STOP -> IDLE.
- START slot:
  - q0-q1: SDA and SCL released.
  - q2-q3: SDA low, SCL released.
  - Slot end: SCL low.
- Byte slot: 8 data bits MSB first, then 1 ACK bit.
  - Data bit: q0-q1 SCL low, SDA driven from the data bit (oe = ~bit); q2-q3 SCL released.
  - ACK bit: SDA released for the whole slot; sda_i sampled on the first clock of q3. 0 = ACK, 1 = NACK.
  - CHIP sends {CHIP_ADDR[7:1],1'b0}; REG sends reg_addr; DATA sends wr_data byte index 0..n-1.
- NACK on any byte: nack_err=1; the remaining bytes are skipped; next slot is STOP.
- STOP slot:
  - q0: SDA low, SCL low.
  - q1-q2: SDA low, SCL released.
  - q3: SDA and SCL released.
  - Last clock of q3: done=1 for 1 cycle; busy=0 on the same edge; IDLE.
- Latency: busy duration = (2 + 9*(2+n))*4*QDIV clocks for n data bytes, ACK throughout, no stretching.
- SDA changes only while SCL is low, except during START and STOP.
- A new start on the cycle after done is accepted.

Optional Feature:
- IICM_CLK_STRETCH_EN defined:
  - In q2 of any slot, the quarter counter holds at 0 while scl_i=0, i.e. the slave is stretching.
  - Timing resumes the cycle after scl_i=1 is seen.
  - busy duration extends by the stretch length.
- Undefined: scl_i ignored; timing is fixed.

Test Plan:
- Reset mid-byte (QDIV=2): assert rstn=0 during CHIP bit 3 -> sda_oe=0, scl_oe=0, busy=0 asynchronously; next start runs a clean transaction.
- QDIV=2, byte_cnt=1, reg_addr=8'h00, wr_data[7:0]=8'hA5, all ACK -> SDA bytes D0, 00, A5 decoded; busy exactly 232 clocks; done pulse 1 cycle; nack_err=0.
- byte_cnt=0 -> only chip and reg bytes, then STOP; busy = 2+18 = 20 slots = 160 clocks at QDIV=2.
- Slave NACKs reg byte (sda_i=1 at ACK q3), byte_cnt=3 -> no data bytes sent; STOP follows; nack_err=1 held after done; next start clears it.
- byte_cnt=7 with MAX_BYTES=4 -> exactly 4 data bytes sent; start pulsed while busy -> ignored, no second transaction.
- IICM_CLK_STRETCH_EN defined: hold scl_i=0 for 10 clocks in q2 of REG bit 0 -> busy extends by exactly 10 clocks; data integrity kept.
